// File: rtl/sprite_pkg.sv
// ============================================================================
// sprite_pkg : shared constants and FSM state type for the sprite blitter
// Rev 1.0
// ============================================================================
`default_nettype none

package sprite_pkg;

  localparam int SPRITE_DIM    = 8;
  localparam int SPRITE_PIXELS = SPRITE_DIM * SPRITE_DIM;
  localparam int FB_WIDTH      = 640;
  localparam int ADDR_W        = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage

`default_nettype wire

// File: rtl/sprite_blit_engine_if.sv
// ============================================================================
// sprite_blit_engine_if : command, sprite-ROM and framebuffer-write signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface sprite_blit_engine_if #(
  parameter int COLOR_W = 8,
  parameter int ADDR_W  = 19,
  parameter int ID_W    = 6
);
  logic                start;
  logic [ADDR_W-1:0]   coordinates;
  logic [ID_W-1:0]     sprite_id;
  logic                busy;
  logic                done;
  logic [ID_W+5:0]     rom_addr;
  logic [COLOR_W-1:0]  rom_data;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [COLOR_W-1:0]  fb_data;
  logic                fb_ready;

  // master: sequencer + ROM + framebuffer side; slave: the blit engine
  modport master (
    output start, coordinates, sprite_id, rom_data, fb_ready,
    input  busy, done, rom_addr, fb_we, fb_addr, fb_data
  );

  modport slave (
    input  start, coordinates, sprite_id, rom_data, fb_ready,
    output busy, done, rom_addr, fb_we, fb_addr, fb_data
  );
endinterface

`default_nettype wire

// File: rtl/sprite_addr.sv
// ============================================================================
// sprite_addr : maps pixel counter 0..63 onto a linear framebuffer address
// Rev 1.0
// ============================================================================
`default_nettype none

module sprite_addr #(
  parameter int FB_WIDTH = 640,
  parameter int ADDR_W   = 19
) (
  input  logic [ADDR_W-1:0] coords,
  input  logic [5:0]        cnt,
  output logic [ADDR_W-1:0] fb_addr
);

  logic [ADDR_W-1:0] row_off;
  logic [ADDR_W-1:0] col_off;

  // Sum wraps modulo 2^ADDR_W by truncation; no overflow indication.
  assign row_off = ADDR_W'(cnt[5:3]) * ADDR_W'(FB_WIDTH);
  assign col_off = ADDR_W'(cnt[2:0]);
  assign fb_addr = coords + row_off + col_off;

endmodule

`default_nettype wire

// File: rtl/sprite_blit_engine.sv
// ============================================================================
// sprite_blit_engine : copies one 8x8 sprite from ROM into the framebuffer.
// Optional colour keying via macro SPRITE_TRANSPARENCY_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sprite_blit_engine #(
  parameter int COLOR_W           = 8,
  parameter int FB_WIDTH          = 640,
  parameter int ADDR_W            = 19,
  parameter int ID_W              = 6,
  parameter int TRANSPARENT_COLOR = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  sprite_blit_engine_if.slave bus
);
  import sprite_pkg::*;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic KEY_EN = 1'b1;
`else
  localparam logic KEY_EN = 1'b0;
`endif
  localparam logic [COLOR_W-1:0] KEY       = COLOR_W'(TRANSPARENT_COLOR);
  localparam logic [5:0]         LAST_PIX  = 6'(SPRITE_PIXELS - 1);

  blit_state_t        state;
  logic [5:0]         cnt;
  logic [ADDR_W-1:0]  coords_q;
  logic [ID_W-1:0]    id_q;
  logic [ADDR_W-1:0]  pix_addr;
  logic               skip;

  // A keyed pixel completes without a write, keeping the 2-cycle cadence.
  assign skip = KEY_EN && (bus.rom_data == KEY);

  assign bus.busy     = (state == READ) || (state == WRITE);
  assign bus.done     = (state == DONE);
  assign bus.fb_we    = (state == WRITE) && !skip;
  assign bus.rom_addr = {id_q, cnt};
  assign bus.fb_addr  = pix_addr;
  assign bus.fb_data  = (state == WRITE) ? bus.rom_data : '0;

  sprite_addr #(
    .FB_WIDTH (FB_WIDTH),
    .ADDR_W   (ADDR_W)
  ) u_addr (
    .coords  (coords_q),
    .cnt     (cnt),
    .fb_addr (pix_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      coords_q <= '0;
      id_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            coords_q <= bus.coordinates;
            id_q     <= bus.sprite_id;
            cnt      <= '0;
            state    <= READ;
          end
        end
        READ: state <= WRITE;
        WRITE: begin
          if (bus.fb_ready || skip) begin
            if (cnt == LAST_PIX) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 6'd1;
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
- Draws one 8x8 sprite into the 640-wide linear framebuffer.
- Sits directly downstream of the pixel-to-framebuffer address generator: owns the 0..63 pixel counter that feeds it and consumes the address it produces.
- Fetches each pixel from the synchronous sprite ROM and issues framebuffer writes with a ready/stall handshake.
- Signals completion to the game-logic sequencer.

Parameters:
- COLOR_W, 8, framebuffer pixel width in bits.
- FB_WIDTH, 640, framebuffer row pitch in pixels.
- ADDR_W, 19, framebuffer address width.
- ID_W, 6, sprite index width; ROM address width is ID_W+6.
- TRANSPARENT_COLOR, 0, colour key skipped when the optional feature is compiled in.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  draw request; sampled only in IDLE.
- coordinates  in  ADDR_W  linear framebuffer address of the sprite's top-left pixel.
- sprite_id  in  ID_W  sprite index.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final pixel.
- rom_addr  out  ID_W+6  {sprite_id_q, cnt}.
- rom_data  in  COLOR_W  sprite ROM data, valid one cycle after rom_addr.
- fb_we  out  1  framebuffer write strobe.
- fb_addr  out  ADDR_W  framebuffer write address.
- fb_data  out  COLOR_W  framebuffer write data.
- fb_ready  in  1  framebuffer accepts the write this cycle.

Behaviour:
- Reset (async, rst_n low): state=IDLE, cnt=0, busy=0, done=0, fb_we=0, fb_addr=0, fb_data=0, rom_addr=0, coords_q=0, id_q=0.
- Reset mid-draw: aborts immediately; no done pulse; no further writes.
- IDLE -> READ on start=1: latches coords_q, id_q; cnt=0; busy=1 next cycle.
- READ (1 cycle): drives rom_addr={id_q,cnt}. Always -> WRITE.
- WRITE:
  - rom_addr held constant, so rom_data stays stable.
  - fb_addr = (coords_q + cnt[5:3]*FB_WIDTH + cnt[2:0]) mod 2^ADDR_W; bit-identical to the address generator, no overflow flag.
  - fb_data = rom_data; fb_we=1.
  - fb_ready=0: stay in WRITE with fb_we, fb_addr, fb_data held.
  - fb_ready=1: the write completes. If cnt==63 -> DONE; else cnt+1 and -> READ.
- DONE (1 cycle): done=1, busy=0, fb_we=0. -> IDLE.
- Outputs are combinational decodes of registered state/cnt/coords_q.
- Unstalled timing: start sampled at edge 0, READ cycle 1, pixel k written in cycle 2+2k, last write cycle 128, done cycle 129. Earliest next start sampled in cycle 130.
- start while busy or in DONE: ignored; coordinates and sprite_id changes during a draw are ignored.
- fb_ready is only examined in WRITE.

Optional Feature:
- Macro SPRITE_TRANSPARENCY_EN.
- Defined: in WRITE, if rom_data==TRANSPARENT_COLOR then fb_we=0. fb_ready is ignored and the state advances as if the write completed (same 2-cycle pixel cadence).
- Undefined: all 64 pixels are written unconditionally; TRANSPARENT_COLOR is unused.

Decomposition:
- Shared package sprite_pkg:
  - constants SPRITE_DIM=8, SPRITE_PIXELS=64, FB_WIDTH=640, ADDR_W=19.
  - state typedef blit_state_t {IDLE, READ, WRITE, DONE}.
- Sub-module: instantiate the existing address generator sprite_addr (inputs coords_q, cnt; output fb_addr). Do not duplicate the arithmetic.

Test Plan:
- Basic draw: start, coordinates=0, sprite_id=0, ROM returns rom_addr[7:0], fb_ready=1 -> 64 writes at 0..7, 640..647, …, 4480..4487 with data 0..63; done in cycle 129; busy high cycles 1..128.
- Offset/id: coordinates=1000, sprite_id=3 -> rom_addr 192..255; first fb_addr 1000, pixel 8 at 1640, last 5487.
- Stall: fb_ready=0 for 5 cycles during pixel 10 (fb_addr 642) -> fb_we/fb_addr/fb_data held all 5 cycles, exactly one write to 642 on release, done in cycle 134.
- Wrap: coordinates=0x7FFFF -> pixel 0 to 0x7FFFF, pixel 1 to 0x00000, pixel 8 to 639.
- Transparency (macro defined): ROM returns 0 for even cnt -> only 32 writes (odd pixels), done still in cycle 129. Macro undefined -> 64 writes.
- Control: start pulsed in cycles 50 and 129 -> ignored, no second draw. rst_n low in cycle 60 -> fb_we=0 immediately, no done, IDLE after release.
